hbm_bench_scheduler: RTL and testbench
======================================

HBM_BENCH_SCHEDULER -- requirements
Module: hbm_bench_scheduler

Interface
REQ-001 SHALL have parameter N_MEM_INTF, default 32, number of HBM traffic engines sequenced (max 32).
REQ-002 SHALL have port hbm_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port hbm_rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start_req  input  1  run request level from control register; a rising edge requests a run.
REQ-005 SHALL have port channel_mask  input  N_MEM_INTF  engines taking part in the run.
REQ-006 SHALL have port par_mode  input  1  0 = sequential (one engine at a time), 1 = parallel (all masked engines together).
REQ-007 SHALL have port timeout_cycles  input  32  per-wait watchdog limit; 0 disables the watchdog.
REQ-008 SHALL have port engine_start  output  N_MEM_INTF  one-cycle start pulse per engine.
REQ-009 SHALL have port engine_done  input  N_MEM_INTF  one-cycle completion pulse per engine.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port run_done  output  1  one-cycle pulse at run end.
REQ-012 SHALL have port timeout_err  output  1  sticky; run ended by watchdog.
REQ-013 SHALL have port cur_channel  output  5  engine currently launched or awaited in sequential mode.
REQ-014 SHALL have port run_cycles  output  64  cycles consumed by the last run.

Function
REQ-015 SHALL use states IDLE, LAUNCH, WAIT, NEXT, FINISH.
REQ-016 SHALL detect the start_req rising edge with a registered copy of start_req; edges outside IDLE SHALL be ignored and not queued.
REQ-017 On an accepted edge SHALL latch channel_mask, par_mode and timeout_cycles, clear timeout_err and run_cycles, and go to LAUNCH; a latched mask of 0 SHALL go directly to FINISH with run_cycles = 0.
REQ-018 Sequential LAUNCH: cur_channel = lowest set bit of the latched mask; engine_start[cur_channel] high for exactly that cycle; next state WAIT.
REQ-019 Sequential WAIT: on engine_done[cur_channel] go to NEXT; done pulses from other engines SHALL be ignored.
REQ-020 NEXT: clear the finished bit in the latched mask; go to LAUNCH for the next-higher set bit if one remains, else FINISH; NEXT SHALL last one cycle.
REQ-021 Parallel LAUNCH: engine_start = latched mask for one cycle; pending register loaded with mask; next state WAIT.
REQ-022 Parallel WAIT: each engine_done bit SHALL clear its pending bit, several bits per cycle allowed; FINISH when pending becomes 0; done on unmasked engines SHALL be ignored.
REQ-023 engine_done SHALL be sampled only in WAIT; engines SHALL NOT complete in the LAUNCH cycle.
REQ-024 Watchdog: counter cleared in LAUNCH, incremented each WAIT cycle; when it equals a nonzero timeout_cycles, set timeout_err and go to FINISH, skipping remaining engines.
REQ-025 If the awaited done and watchdog expiry occur in the same cycle, done SHALL win and timeout_err SHALL stay 0.
REQ-026 run_cycles SHALL increment every cycle in LAUNCH, WAIT and NEXT, and SHALL hold from FINISH until the next accepted start; it SHALL saturate at all-ones.
REQ-027 FINISH SHALL assert run_done for one cycle and return to IDLE; busy SHALL be low again in the following cycle.
REQ-028 engine_start SHALL be registered and SHALL never be high outside LAUNCH.

Reset
REQ-029 With hbm_rstn low all outputs SHALL be 0, the state SHALL be IDLE, and the latched mask, pending, watchdog and edge register SHALL be 0.
REQ-030 Reset asserted mid-run SHALL abort immediately, with no run_done pulse; a start_req held high through reset release SHALL NOT start a run until it falls and rises again.

Verification
REQ-031 Sequential run, mask = 0x5, each engine done 10 cycles after start -> start pulses on engines 0 then 2; cur_channel 0 then 2; run_done once; run_cycles = 24; timeout_err = 0.
REQ-032 Parallel run, mask = 0xF, done on engines 0/1/2/3 at WAIT cycles 3/3/7/5 -> all four start pulses in one cycle; FINISH follows the cycle-7 done; run_cycles = 8.
REQ-033 Sequential run, mask = 0x1, timeout_cycles = 20, no done -> timeout_err = 1, run_done after 20 WAIT cycles, run_cycles = 21.
REQ-034 Done arrives on the same cycle the watchdog hits 20 -> timeout_err = 0, normal completion.
REQ-035 Mask = 0 -> run_done within 2 cycles of the edge, run_cycles = 0, no engine_start; a second start_req edge while busy -> no effect.
REQ-036 hbm_rstn pulsed low during WAIT -> busy = 0 and engine_start = 0 at once, no run_done, run_cycles = 0.

Source files
------------

// File: rtl/hbm_bench_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hbm_bench_scheduler_if : run control and engine handshake bundle          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface hbm_bench_scheduler_if #(
  parameter int N_MEM_INTF = 32
);
  logic                  start_req;
  logic [N_MEM_INTF-1:0] channel_mask;
  logic                  par_mode;
  logic [31:0]           timeout_cycles;
  logic [N_MEM_INTF-1:0] engine_start;
  logic [N_MEM_INTF-1:0] engine_done;
  logic                  busy;
  logic                  run_done;
  logic                  timeout_err;
  logic [4:0]            cur_channel;
  logic [63:0]           run_cycles;

  modport master (
    output start_req, channel_mask, par_mode, timeout_cycles, engine_done,
    input  engine_start, busy, run_done, timeout_err, cur_channel, run_cycles
  );

  modport slave (
    input  start_req, channel_mask, par_mode, timeout_cycles, engine_done,
    output engine_start, busy, run_done, timeout_err, cur_channel, run_cycles
  );
endinterface
`default_nettype wire

// File: rtl/hbm_bench_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hbm_bench_scheduler : launches HBM traffic engines one-by-one or together, |
// | with a per-wait watchdog and a saturating run-length counter.             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module hbm_bench_scheduler #(
  parameter int N_MEM_INTF = 32
) (
  input  logic                 hbm_clk,
  input  logic                 hbm_rstn,
  hbm_bench_scheduler_if.slave sched
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [N_MEM_INTF-1:0] c_one = N_MEM_INTF'(1);

  state_t                r_state;
  logic                  r_start_q;
  logic                  r_armed;
  logic [N_MEM_INTF-1:0] r_mask;
  logic                  r_par;
  logic [31:0]           r_tmo;
  logic [N_MEM_INTF-1:0] r_pending;
  logic [31:0]           r_wdog;
  logic [N_MEM_INTF-1:0] r_engine_start;
  logic [4:0]            r_cur_channel;
  logic [63:0]           r_run_cycles;
  logic                  r_timeout_err;

  state_t                w_state_next;
  logic                  w_start_edge;
  logic                  w_set_err;
  logic [N_MEM_INTF-1:0] w_mask_rem;
  logic [N_MEM_INTF-1:0] w_launch_src;
  logic                  w_launch_par;
  logic [4:0]            w_launch_idx;
  logic [N_MEM_INTF-1:0] w_launch_vec;
  logic [N_MEM_INTF-1:0] w_done_shift;
  logic                  w_cur_done;
  logic [N_MEM_INTF-1:0] w_pend_next;
  logic [31:0]           w_wdog_inc;
  logic                  w_wdog_hit;
  logic                  w_counting;

  function automatic logic [4:0] lowest_set(input logic [N_MEM_INTF-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = N_MEM_INTF - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // r_armed keeps a start_req held high across reset from being seen as an edge
  assign w_start_edge = (r_state == S_IDLE) && sched.start_req && !r_start_q && r_armed;
  assign w_mask_rem   = r_mask & ~(c_one << r_cur_channel);
  assign w_launch_src = (r_state == S_IDLE) ? sched.channel_mask : w_mask_rem;
  assign w_launch_par = (r_state == S_IDLE) ? sched.par_mode : r_par;
  assign w_launch_idx = lowest_set(w_launch_src);
  assign w_launch_vec = w_launch_par ? w_launch_src : (c_one << w_launch_idx);
  assign w_done_shift = sched.engine_done >> r_cur_channel;
  assign w_cur_done   = w_done_shift[0];
  assign w_pend_next  = r_pending & ~sched.engine_done;
  assign w_wdog_inc   = r_wdog + 32'd1;
  assign w_wdog_hit   = (r_tmo != 32'd0) && (w_wdog_inc == r_tmo);
  assign w_counting   = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_NEXT);

  always_comb begin
    w_state_next = r_state;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_next = (sched.channel_mask == '0) ? S_FINISH : S_LAUNCH;
        end
      end
      S_LAUNCH: w_state_next = S_WAIT;
      S_WAIT: begin
        // a completing done beats a watchdog expiry in the same cycle
        if (r_par && (w_pend_next == '0)) begin
          w_state_next = S_FINISH;
        end else if (!r_par && w_cur_done) begin
          w_state_next = S_NEXT;
        end else if (w_wdog_hit) begin
          w_state_next = S_FINISH;
          w_set_err    = 1'b1;
        end
      end
      S_NEXT:   w_state_next = (w_mask_rem == '0) ? S_FINISH : S_LAUNCH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hbm_clk or negedge hbm_rstn) begin
    if (!hbm_rstn) begin
      r_state        <= S_IDLE;
      r_start_q      <= 1'b0;
      r_armed        <= 1'b0;
      r_mask         <= '0;
      r_par          <= 1'b0;
      r_tmo          <= '0;
      r_pending      <= '0;
      r_wdog         <= '0;
      r_engine_start <= '0;
      r_cur_channel  <= '0;
      r_run_cycles   <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_start_q      <= sched.start_req;
      r_engine_start <= (w_state_next == S_LAUNCH) ? w_launch_vec : '0;
      if (!sched.start_req) r_armed <= 1'b1;
      if ((w_state_next == S_LAUNCH) && !w_launch_par) r_cur_channel <= w_launch_idx;

      if (w_start_edge) begin
        r_mask        <= sched.channel_mask;
        r_par         <= sched.par_mode;
        r_tmo         <= sched.timeout_cycles;
        r_timeout_err <= 1'b0;
        r_run_cycles  <= '0;
      end else if (w_counting && (r_run_cycles != '1)) begin
        r_run_cycles  <= r_run_cycles + 64'd1;
      end

      if (r_state == S_NEXT) r_mask <= w_mask_rem;

      if (r_state == S_LAUNCH) begin
        r_wdog    <= '0;
        r_pending <= r_mask;
      end else if (r_state == S_WAIT) begin
        r_wdog    <= w_wdog_inc;
        r_pending <= w_pend_next;
      end

      if (w_set_err) r_timeout_err <= 1'b1;
    end
  end

  assign sched.engine_start = r_engine_start;
  assign sched.busy         = (r_state != S_IDLE);
  assign sched.run_done     = (r_state == S_FINISH);
  assign sched.timeout_err  = r_timeout_err;
  assign sched.cur_channel  = r_cur_channel;
  assign sched.run_cycles   = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hbm_bench_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hbm_bench_scheduler : directed vector bench for hbm_bench_scheduler     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_hbm_bench_scheduler;

  localparam int N = 32;

  logic hbm_clk = 1'b0;
  logic hbm_rstn;
  int   n_checks = 0;
  int   n_pass   = 0;

  hbm_bench_scheduler_if #(.N_MEM_INTF(N)) sched ();

  hbm_bench_scheduler #(.N_MEM_INTF(N)) dut (
    .hbm_clk  (hbm_clk),
    .hbm_rstn (hbm_rstn),
    .sched    (sched)
  );

  always #5 hbm_clk = ~hbm_clk;

  // delay d: engine answers d cycles after its start pulse, 0 = never answers
  typedef struct {
    logic [31:0] mask;
    logic        par;
    logic [31:0] tmo;
    int          d0, d1, d2, d3, d_hi;
    logic [31:0] noise;
    logic [63:0] exp_cycles;
    logic        exp_tmo;
    logic [31:0] exp_starts;
    int          exp_launch;
    int          exp_lat;
    int          exp_seq;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int delay_of(input vec_t v, input int i);
    case (i)
      0:       return v.d0;
      1:       return v.d1;
      2:       return v.d2;
      3:       return v.d3;
      default: return v.d_hi;
    endcase
  endfunction

  task automatic run_vec(input int vi);
    vec_t        v;
    int          cnt [N];
    logic [31:0] done_v;
    logic [31:0] start_or;
    int          launches, lat, seq, onehot_bad, extra;
    v = vecs[vi];
    @(negedge hbm_clk);
    sched.start_req      = 1'b0;
    sched.channel_mask   = v.mask;
    sched.par_mode       = v.par;
    sched.timeout_cycles = v.tmo;
    sched.engine_done    = v.noise;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    @(negedge hbm_clk);
    sched.start_req = 1'b1;
    start_or = '0; launches = 0; lat = -1; seq = 0; onehot_bad = 0;
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      @(negedge hbm_clk);
      if (sched.engine_start != '0) begin
        launches++;
        start_or |= sched.engine_start;
        if (!v.par) begin
          seq = (seq << 5) | int'(sched.cur_channel);
          if (sched.engine_start != (32'd1 << sched.cur_channel)) onehot_bad++;
        end
      end
      if (sched.run_done) lat = c;
      done_v = v.noise;
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) done_v[i] = 1'b1;
        end
        if (sched.engine_start[i] && delay_of(v, i) > 0) cnt[i] = delay_of(v, i);
      end
      sched.engine_done = done_v;
    end
    check($sformatf("v%0d latency", vi), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d run_cycles", vi), sched.run_cycles, v.exp_cycles);
    check($sformatf("v%0d timeout_err", vi), 64'(sched.timeout_err), 64'(v.exp_tmo));
    check($sformatf("v%0d started", vi), 64'(start_or), 64'(v.exp_starts));
    check($sformatf("v%0d launches", vi), 64'(launches), 64'(v.exp_launch));
    if (!v.par) begin
      check($sformatf("v%0d channel_seq", vi), 64'(seq), 64'(v.exp_seq));
      check($sformatf("v%0d onehot_start", vi), 64'(onehot_bad), 64'd0);
    end
    sched.start_req   = 1'b0;
    sched.engine_done = '0;
    extra = 0;
    repeat (3) begin
      @(negedge hbm_clk);
      if (sched.busy || sched.run_done || sched.engine_start != '0) extra++;
    end
    check($sformatf("v%0d idle_after", vi), 64'(extra), 64'd0);
    check($sformatf("v%0d cycles_hold", vi), sched.run_cycles, v.exp_cycles);
    check($sformatf("v%0d tmo_sticky", vi), 64'(sched.timeout_err), 64'(v.exp_tmo));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    //          mask          par   tmo     d0  d1  d2  d3  dhi noise         cyc     tmo   starts        ln lat seq
    vecs[0] = '{32'h0000_0005, 1'b0, 32'd0,  10, 10, 10, 10, 0, 32'h0000_0002, 64'd24, 1'b0, 32'h0000_0005, 2, 25, 2};
    vecs[1] = '{32'h0000_000F, 1'b1, 32'd0,  3,  3,  7,  5,  0, 32'h0000_0030, 64'd8,  1'b0, 32'h0000_000F, 1, 9,  0};
    vecs[2] = '{32'h0000_0001, 1'b0, 32'd20, 0,  0,  0,  0,  0, 32'h0000_0000, 64'd21, 1'b1, 32'h0000_0001, 1, 22, 0};
    vecs[3] = '{32'h0000_0001, 1'b0, 32'd20, 20, 0,  0,  0,  0, 32'h0000_0000, 64'd22, 1'b0, 32'h0000_0001, 1, 23, 0};
    vecs[4] = '{32'h0000_0000, 1'b0, 32'd0,  0,  0,  0,  0,  0, 32'h0000_0000, 64'd0,  1'b0, 32'h0000_0000, 0, 1,  0};
    vecs[5] = '{32'h0000_0005, 1'b0, 32'd15, 4,  0,  0,  0,  0, 32'h0000_0000, 64'd22, 1'b1, 32'h0000_0005, 2, 23, 2};
    vecs[6] = '{32'h0000_0003, 1'b1, 32'd6,  2,  0,  0,  0,  0, 32'h0000_0000, 64'd7,  1'b1, 32'h0000_0003, 1, 8,  0};
    vecs[7] = '{32'h0000_000A, 1'b0, 32'd0,  0,  1,  0,  2,  0, 32'h0000_0000, 64'd7,  1'b0, 32'h0000_000A, 2, 8,  35};
    vecs[8] = '{32'h8000_0001, 1'b0, 32'd0,  1,  0,  0,  0,  3, 32'h0000_0000, 64'd8,  1'b0, 32'h8000_0001, 2, 9,  31};
    vecs[9] = '{32'h0F00_0000, 1'b1, 32'd0,  0,  0,  0,  0,  4, 32'h0000_0001, 64'd5,  1'b0, 32'h0F00_0000, 1, 6,  0};

    hbm_rstn             = 1'b0;
    sched.start_req      = 1'b1;
    sched.channel_mask   = 32'h1;
    sched.par_mode       = 1'b0;
    sched.timeout_cycles = 32'd3;
    sched.engine_done    = '0;
    repeat (3) @(negedge hbm_clk);
    check("rst busy", 64'(sched.busy), 64'd0);
    check("rst run_done", 64'(sched.run_done), 64'd0);
    check("rst engine_start", 64'(sched.engine_start), 64'd0);
    check("rst timeout_err", 64'(sched.timeout_err), 64'd0);
    check("rst cur_channel", 64'(sched.cur_channel), 64'd0);
    check("rst run_cycles", sched.run_cycles, 64'd0);

    // start_req stays high across reset release and must not launch a run
    hbm_rstn = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge hbm_clk);
      if (sched.busy) bad++;
    end
    check("held_start_ignored", 64'(bad), 64'd0);
    sched.start_req = 1'b0;
    @(negedge hbm_clk);
    sched.start_req = 1'b1;
    @(negedge hbm_clk);
    check("rearm busy", 64'(sched.busy), 64'd1);
    check("rearm engine_start", 64'(sched.engine_start), 64'd1);
    for (int k = 0; k < 30 && sched.busy; k++) @(negedge hbm_clk);
    check("rearm finished", 64'(sched.busy), 64'd0);
    check("rearm timeout_err", 64'(sched.timeout_err), 64'd1);
    check("rearm run_cycles", sched.run_cycles, 64'd4);

    for (int vi = 0; vi < 10; vi++) run_vec(vi);

    // second rising edge while busy must be dropped, not queued
    @(negedge hbm_clk);
    sched.start_req      = 1'b0;
    sched.channel_mask   = 32'h2;
    sched.par_mode       = 1'b0;
    sched.timeout_cycles = 32'd5;
    sched.engine_done    = '0;
    @(negedge hbm_clk);
    sched.start_req = 1'b1;
    @(negedge hbm_clk);
    check("busy_edge launch", 64'(sched.engine_start), 64'd2);
    check("busy_edge cur_channel", 64'(sched.cur_channel), 64'd1);
    @(negedge hbm_clk);
    sched.start_req = 1'b0;
    @(negedge hbm_clk);
    sched.start_req = 1'b1;
    for (int k = 0; k < 30 && sched.busy; k++) @(negedge hbm_clk);
    bad = 0;
    repeat (6) begin
      @(negedge hbm_clk);
      if (sched.busy || sched.engine_start != '0) bad++;
    end
    check("busy_edge not_queued", 64'(bad), 64'd0);
    check("busy_edge timeout_err", 64'(sched.timeout_err), 64'd1);
    check("busy_edge run_cycles", sched.run_cycles, 64'd6);

    // asynchronous reset in the middle of a wait
    sched.start_req      = 1'b0;
    sched.channel_mask   = 32'h1;
    sched.timeout_cycles = 32'd0;
    @(negedge hbm_clk);
    sched.start_req = 1'b1;
    repeat (3) @(negedge hbm_clk);
    check("midrun busy_before", 64'(sched.busy), 64'd1);
    hbm_rstn = 1'b0;
    #1;
    check("midrun busy", 64'(sched.busy), 64'd0);
    check("midrun engine_start", 64'(sched.engine_start), 64'd0);
    check("midrun run_cycles", sched.run_cycles, 64'd0);
    bad = 0;
    repeat (3) begin
      @(negedge hbm_clk);
      if (sched.run_done || sched.busy) bad++;
    end
    check("midrun no_run_done", 64'(bad), 64'd0);
    sched.start_req = 1'b0;
    hbm_rstn        = 1'b1;
    repeat (2) @(negedge hbm_clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
